vx_afu_run_ctrl: RTL and testbench

- Parametrised AFU run-control engine: sequences processor reset, start, busy tracking and completion for N AXI memory banks.
- Tracks outstanding writes per bank, with saturation/error detection.
- Adds a busy-wait watchdog and a run-cycle counter.
- Sits between the AXI-Lite control block (ap_* handshake) and the Vortex AXI core wrapper, replacing inline run/reset/pending-write logic.

---
 rtl/vx_afu_pkg.sv | 30 +++
 rtl/vx_afu_pending_ctr.sv | 49 ++++
 rtl/vx_afu_run_ctrl.sv | 155 +++++++++++++++
 tb/tb_vx_afu_run_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_afu_pkg.sv
// Shared state encoding and saturating counter step for the AFU run-control engine.
// Pure declarations: no clocked logic and no handshakes.
package vx_afu_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // One step of a counter that sticks at 0 and at max; up and dn together cancel.
  function automatic logic [63:0] sat_updown(input logic [63:0] val,
                                             input logic [63:0] max,
                                             input logic        up,
                                             input logic        dn);
    logic [63:0] res;
    res = val;
    if (up && !dn && val != max) begin
      res = val + 64'd1;
    end else if (dn && !up && val != 64'd0) begin
      res = val - 64'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/vx_afu_pending_ctr.sv
// Per-bank outstanding-write counter with sticky overflow/underflow flags.
// One-cycle update latency; never stalls AW/B, bad events are flagged and the count holds.
module vx_afu_pending_ctr
  import vx_afu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic ovf,
  output logic unf
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = W'(sat_updown(64'(count), 64'(MAX), inc, dec));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_d;
      if (inc && !dec && count == MAX) begin
        ovf <= 1'b1;
      end
      if (dec && !inc && count == '0) begin
        unf <= 1'b1;
      end
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/vx_afu_run_ctrl.sv
// Run-control engine: processor reset, start, busy tracking, drain and ap_done for N banks.
// ap_done is registered, one cycle after DRAIN sees no pending writes; ap_start is level and ignored unless idle.
module vx_afu_run_ctrl
  import vx_afu_pkg::*;
#(
  parameter int NUM_BANKS   = 1,
  parameter int RESET_DELAY = 8,
  parameter int PENDING_W   = 16,
  parameter int TIMEOUT_W   = 16,
  parameter int CYCLE_W     = 48
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_reset,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_ready,
  output logic                 ap_idle,
  output logic                 vx_reset,
  input  logic                 vx_busy,
  input  logic [NUM_BANKS-1:0] awfire,
  input  logic [NUM_BANKS-1:0] bfire,
  input  logic [TIMEOUT_W-1:0] busy_timeout,
  output logic                 pending_any,
  output logic [CYCLE_W-1:0]   run_cycles,
  output logic                 timed_out,
  output logic [NUM_BANKS-1:0] err_overflow,
  output logic [NUM_BANKS-1:0] err_underflow
);

  localparam int RCNT_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [RCNT_W-1:0]  RD_LAST = RCNT_W'(RESET_DELAY - 1);
  localparam logic [CYCLE_W-1:0] CYC_MAX = '1;

  state_t               state_q;
  state_t               state_d;
  logic [RCNT_W-1:0]    rst_cnt_q;
  logic [RCNT_W-1:0]    rst_cnt_d;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [TIMEOUT_W-1:0] wd_d;
  logic                 timed_out_d;
  logic                 done_d;
  logic                 vx_reset_d;
  logic                 cyc_clr;
  logic [CYCLE_W-1:0]   cyc_inc;
  logic [NUM_BANKS-1:0] bank_nz;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    vx_afu_pending_ctr #(
      .W(PENDING_W)
    ) u_ctr (
      .clk     (ap_clk),
      .rst_n   (ap_rst_n),
      .clr     (ap_reset),
      .inc     (awfire[i]),
      .dec     (bfire[i]),
      .nonzero (bank_nz[i]),
      .ovf     (err_overflow[i]),
      .unf     (err_underflow[i])
    );
  end

  assign pending_any = |bank_nz;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    wd_d        = wd_q;
    timed_out_d = timed_out;
    done_d      = 1'b0;
    cyc_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d     = ST_RESET;
          rst_cnt_d   = '0;
          timed_out_d = 1'b0;
          cyc_clr     = 1'b1;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RD_LAST) begin
          state_d = ST_WAIT_BUSY;
          wd_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCNT_W'(1);
        end
      end
      ST_WAIT_BUSY: begin
        // A busy seen on the expiry cycle wins over the watchdog.
        if (vx_busy) begin
          state_d = ST_RUN;
        end else if (busy_timeout != '0 && wd_q == (busy_timeout - TIMEOUT_W'(1))) begin
          state_d     = ST_DRAIN;
          timed_out_d = 1'b1;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      ST_RUN: begin
        if (!vx_busy) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pending_any) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Processor reset is released one cycle after leaving RESET and reasserted on return to IDLE.
    vx_reset_d = (state_d == ST_IDLE) || (state_q == ST_IDLE) || (state_q == ST_RESET);
    cyc_inc    = CYCLE_W'(sat_updown(64'(run_cycles), 64'(CYC_MAX), 1'b1, 1'b0));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      rst_cnt_q  <= '0;
      wd_q       <= '0;
      timed_out  <= 1'b0;
      run_cycles <= '0;
      ap_done    <= 1'b0;
      vx_reset   <= 1'b1;
    end else if (ap_reset) begin
      state_q    <= ST_IDLE;
      rst_cnt_q  <= '0;
      wd_q       <= '0;
      timed_out  <= 1'b0;
      run_cycles <= '0;
      ap_done    <= 1'b0;
      vx_reset   <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      wd_q      <= wd_d;
      timed_out <= timed_out_d;
      ap_done   <= done_d;
      vx_reset  <= vx_reset_d;
      if (cyc_clr) begin
        run_cycles <= '0;
      end else if (state_q != ST_IDLE) begin
        run_cycles <= cyc_inc;
      end
    end
  end

  assign ap_ready = ap_done;
  assign ap_idle  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vx_afu_run_ctrl.sv
// Bench for vx_afu_run_ctrl: phase/age reference model checked every cycle,
// plus a pending-counter vector table and hand-timed run sequences.
module tb_vx_afu_run_ctrl;

  localparam int NB = 2;
  localparam int RD = 8;
  localparam int PW = 2;
  localparam int TW = 16;
  localparam int CW = 48;
  localparam int PMAX = (1 << PW) - 1;
  localparam logic [63:0] CYC_MAX = (64'd1 << CW) - 64'd1;
  localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_RUN = 3, P_DRAIN = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_reset;
  logic          ap_start;
  logic          ap_done;
  logic          ap_ready;
  logic          ap_idle;
  logic          vx_reset;
  logic          vx_busy;
  logic [NB-1:0] awfire;
  logic [NB-1:0] bfire;
  logic [TW-1:0] busy_timeout;
  logic          pending_any;
  logic [CW-1:0] run_cycles;
  logic          timed_out;
  logic [NB-1:0] err_overflow;
  logic [NB-1:0] err_underflow;

  always #5 ap_clk = ~ap_clk;

  vx_afu_run_ctrl #(
    .NUM_BANKS(NB), .RESET_DELAY(RD), .PENDING_W(PW), .TIMEOUT_W(TW), .CYCLE_W(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_reset(ap_reset), .ap_start(ap_start),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .vx_reset(vx_reset),
    .vx_busy(vx_busy), .awfire(awfire), .bfire(bfire), .busy_timeout(busy_timeout),
    .pending_any(pending_any), .run_cycles(run_cycles), .timed_out(timed_out),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  int n_checks = 0;
  int n_err = 0;

  // Model: which phase we are in and how many cycles we have spent there.
  int          m_phase;
  int          m_age;
  logic [63:0] m_cycles;
  bit          m_to, m_done, m_vxr;
  int          m_pend[NB];
  bit [NB-1:0] m_ovf, m_unf;

  typedef struct {
    logic [NB-1:0] aw;
    logic [NB-1:0] b;
    logic          pend;
    logic [NB-1:0] ovf;
    logic [NB-1:0] unf;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pend_any();
    bit any = 0;
    foreach (m_pend[i]) if (m_pend[i] != 0) any = 1;
    return any;
  endfunction

  task automatic m_clear();
    m_phase = P_IDLE; m_age = 0; m_cycles = 0; m_to = 0; m_done = 0; m_vxr = 1;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_ovf = '0; m_unf = '0;
  endtask

  task automatic m_step();
    int np;
    bit any;
    if (ap_reset) begin
      m_clear();
      return;
    end
    any = m_pend_any();
    np = m_phase;
    m_done = 0;
    case (m_phase)
      P_IDLE:  if (ap_start) begin np = P_RST; m_cycles = 0; m_to = 0; end
      P_RST:   if (m_age == RD) np = P_WAIT;
      P_WAIT:  if (vx_busy) np = P_RUN;
               else if (busy_timeout != 0 && m_age == int'(busy_timeout)) begin np = P_DRAIN; m_to = 1; end
      P_RUN:   if (!vx_busy) np = P_DRAIN;
      P_DRAIN: if (!any) begin np = P_IDLE; m_done = 1; end
      default: np = P_IDLE;
    endcase
    if (m_phase != P_IDLE && m_cycles < CYC_MAX) m_cycles++;
    if (np != m_phase) m_age = 1; else m_age++;
    m_vxr = (np == P_IDLE) || (np == P_RST) || (np == P_WAIT && m_age == 1);
    for (int i = 0; i < NB; i++) begin
      if (awfire[i] && !bfire[i]) begin
        if (m_pend[i] == PMAX) m_ovf[i] = 1; else m_pend[i]++;
      end else if (bfire[i] && !awfire[i]) begin
        if (m_pend[i] == 0) m_unf[i] = 1; else m_pend[i]--;
      end
    end
    m_phase = np;
  endtask

  task automatic check_all();
    chk("ap_done", ap_done, m_done);
    chk("ap_ready", ap_ready, m_done);
    chk("ap_idle", ap_idle, m_phase == P_IDLE);
    chk("vx_reset", vx_reset, m_vxr);
    chk("pending_any", pending_any, m_pend_any());
    chk("run_cycles", run_cycles, m_cycles);
    chk("timed_out", timed_out, m_to);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_underflow", err_underflow, m_unf);
  endtask

  task automatic cycle();
    m_step();
    @(posedge ap_clk);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #3 ap_rst_n = 1'b0;
    #1 m_clear();
    check_all();
    #2 ap_rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    ap_start = 1'b1;
    cycle();
    ap_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int done_at, low_at, i12, i13, i60;
    logic [63:0] cyc_at, to_at;

    ap_rst_n = 1'b0; ap_reset = 1'b0; ap_start = 1'b0; vx_busy = 1'b0;
    awfire = '0; bfire = '0; busy_timeout = '0;
    m_clear();
    #12;
    chk("rst_idle", ap_idle, 1);
    chk("rst_vx_reset", vx_reset, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_pending", pending_any, 0);
    chk("rst_cycles", run_cycles, 0);
    ap_rst_n = 1'b1;
    cycle();

    // Basic run: busy sampled high on edges 13..40.
    busy_timeout = 0;
    start_pulse();
    done_at = -1; low_at = -1; cyc_at = 0;
    for (int c = 1; c <= 45; c++) begin
      vx_busy = (c >= 13 && c <= 40);
      cycle();
      if (!vx_reset && low_at < 0) low_at = c;
      if (ap_done && done_at < 0) begin done_at = c; cyc_at = run_cycles; end
    end
    vx_busy = 1'b0;
    chk("basic_vx_reset_low_at", low_at, 9);
    chk("basic_done_at", done_at, 42);
    chk("basic_run_cycles", cyc_at, 42);

    // Drain: three writes on bank1, responses trickle in after busy drops.
    start_pulse();
    done_at = -1; i60 = -1;
    for (int c = 1; c <= 65; c++) begin
      vx_busy = (c >= 13 && c <= 45);
      awfire = (c >= 20 && c <= 22) ? 2'b10 : 2'b00;
      bfire  = (c == 50 || c == 55 || c == 60) ? 2'b10 : 2'b00;
      cycle();
      if (c == 60) i60 = ap_idle;
      if (ap_done && done_at < 0) done_at = c;
    end
    vx_busy = 1'b0; awfire = '0; bfire = '0;
    chk("drain_not_idle_at60", i60, 0);
    chk("drain_done_at", done_at, 61);
    chk("drain_pending_after", pending_any, 0);

    // Watchdog expiry with busy never seen.
    busy_timeout = 5;
    start_pulse();
    done_at = -1; cyc_at = 0; to_at = 0;
    for (int c = 1; c <= 16; c++) begin
      cycle();
      if (ap_done && done_at < 0) begin done_at = c; cyc_at = run_cycles; to_at = timed_out; end
    end
    chk("wd_done_at", done_at, RD + 5 + 1);
    chk("wd_run_cycles", cyc_at, 14);
    chk("wd_timed_out", to_at, 1);

    // Next start clears timed_out; busy on the expiry cycle wins.
    start_pulse();
    chk("wd_to_cleared", timed_out, 0);
    done_at = -1;
    for (int c = 1; c <= 18; c++) begin
      vx_busy = (c == 13);
      cycle();
      if (ap_done && done_at < 0) done_at = c;
    end
    vx_busy = 1'b0;
    chk("wd_busy_prio_done_at", done_at, 15);
    chk("wd_busy_prio_to", timed_out, 0);

    // ap_start held high: next run accepted right after IDLE is re-entered.
    busy_timeout = 3;
    ap_start = 1'b1;
    cycle();
    done_at = -1; i12 = -1; i13 = -1;
    for (int c = 1; c <= 14; c++) begin
      cycle();
      if (c == 12) i12 = ap_idle;
      if (c == 13) i13 = ap_idle;
      if (ap_done && done_at < 0) done_at = c;
    end
    ap_start = 1'b0;
    chk("held_done_at", done_at, 12);
    chk("held_idle_at12", i12, 1);
    chk("held_idle_at13", i13, 0);
    for (int c = 0; c < 15; c++) cycle();

    // Pending counter vectors, starting from cleared flags.
    ap_reset = 1'b1; cycle(); ap_reset = 1'b0;
    tbl[0]  = '{2'b01, 2'b00, 1'b1, 2'b00, 2'b00};
    tbl[1]  = '{2'b01, 2'b00, 1'b1, 2'b00, 2'b00};
    tbl[2]  = '{2'b01, 2'b00, 1'b1, 2'b00, 2'b00};
    tbl[3]  = '{2'b01, 2'b00, 1'b1, 2'b01, 2'b00};
    tbl[4]  = '{2'b00, 2'b10, 1'b1, 2'b01, 2'b10};
    tbl[5]  = '{2'b10, 2'b10, 1'b1, 2'b01, 2'b10};
    tbl[6]  = '{2'b00, 2'b01, 1'b1, 2'b01, 2'b10};
    tbl[7]  = '{2'b00, 2'b01, 1'b1, 2'b01, 2'b10};
    tbl[8]  = '{2'b00, 2'b01, 1'b0, 2'b01, 2'b10};
    tbl[9]  = '{2'b11, 2'b11, 1'b0, 2'b01, 2'b10};
    tbl[10] = '{2'b00, 2'b01, 1'b0, 2'b01, 2'b11};
    tbl[11] = '{2'b10, 2'b00, 1'b1, 2'b01, 2'b11};
    tbl[12] = '{2'b00, 2'b10, 1'b0, 2'b01, 2'b11};
    for (int i = 0; i < 13; i++) begin
      awfire = tbl[i].aw;
      bfire  = tbl[i].b;
      cycle();
      chk($sformatf("tbl%0d_pending", i), pending_any, tbl[i].pend);
      chk($sformatf("tbl%0d_ovf", i), err_overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), err_underflow, tbl[i].unf);
    end
    awfire = '0; bfire = '0;

    // Soft reset mid-run with two writes outstanding.
    busy_timeout = 0;
    for (int pass = 0; pass < 2; pass++) begin
      start_pulse();
      for (int c = 1; c <= 25; c++) begin
        vx_busy = (c >= 10);
        awfire = (c == 20 || c == 21) ? 2'b01 : 2'b00;
        cycle();
      end
      awfire = '0;
      chk($sformatf("midrst%0d_pending_before", pass), pending_any, 1);
      chk($sformatf("midrst%0d_running", pass), ap_idle, 0);
      if (pass == 0) begin
        ap_reset = 1'b1; cycle(); ap_reset = 1'b0;
      end else begin
        async_reset();
      end
      vx_busy = 1'b0;
      chk($sformatf("midrst%0d_idle", pass), ap_idle, 1);
      chk($sformatf("midrst%0d_vx_reset", pass), vx_reset, 1);
      chk($sformatf("midrst%0d_pending", pass), pending_any, 0);
      chk($sformatf("midrst%0d_done", pass), ap_done, 0);
      bfire = 2'b01; cycle(); bfire = '0;
      chk($sformatf("midrst%0d_late_b_unf", pass), err_underflow, 2'b01);
      cycle();
      chk($sformatf("midrst%0d_no_done", pass), ap_done, 0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (m_phase == P_IDLE && $urandom_range(0, 3) == 0) busy_timeout = TW'($urandom_range(0, 6));
      ap_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) vx_busy = ~vx_busy;
      for (int b = 0; b < NB; b++) begin
        awfire[b] = ($urandom_range(0, 3) == 0);
        bfire[b]  = ($urandom_range(0, 3) == 0);
      end
      ap_reset = ($urandom_range(0, 299) == 0);
      cycle();
      if (c == 1500) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
